// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB register-file slave.
package apb_slave_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } apb_state_e;

   localparam logic [31:0] ID_VALUE = 32'hA9B0_0001;

   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_ADDR_WIDTH  = 32;
   localparam int DEF_DEPTH       = 16;
   localparam int DEF_WAIT_STATES = 2;

   // Wait counter covers WAIT_STATES up to 15.
   localparam int CNT_W = 4;

endpackage

// File: rtl/apb_slave_regbank.sv
// Register storage: one synchronous write port, one asynchronous read port.
module apb_slave_regbank
   import apb_slave_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int IDX_W      = $clog2(DEF_DEPTH)
) (
   input  logic                  i_clk_apb,
   input  logic                  i_rst_apb,
   input  logic                  i_we,
   input  logic [IDX_W-1:0]      i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [IDX_W-1:0]      i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] reg_vec [DEPTH];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
         logic [DATA_WIDTH-1:0] reg_q;

         always_ff @(posedge i_clk_apb) begin
            if (i_rst_apb) begin
               reg_q <= '0;
            end else if (i_we && (i_waddr == IDX_W'(gi))) begin
               reg_q <= i_wdata;
            end
         end

         assign reg_vec[gi] = reg_q;
      end
   endgenerate

   assign o_rdata = reg_vec[i_raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave exposing DEPTH 32-bit registers with a fixed number of wait states;
// register 0 is a read-only ID word.
module apb_slave_mem
   import apb_slave_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int WAIT_STATES = DEF_WAIT_STATES
) (
   input  logic                  i_clk_apb,
   input  logic                  i_rst_apb,
   input  logic                  i_psel,
   input  logic                  i_penable,
   input  logic                  i_pwrite,
   input  logic [ADDR_WIDTH-1:0] i_paddr,
   input  logic [DATA_WIDTH-1:0] i_pwdata,
   output logic [DATA_WIDTH-1:0] o_prdata,
   output logic                  o_pready,
   output logic                  o_pslverr
);

   localparam int IDX_W = $clog2(DEPTH);

   apb_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  write_q, write_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  err_q, err_d;

   logic                  setup;
   logic                  addr_err;
   logic                  ready;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] bank_rdata;
   logic [DATA_WIDTH-1:0] rd_word;

   assign setup = i_psel && !i_penable;

   // Misaligned, beyond the register window, or a write to the ID register.
   assign addr_err = (i_paddr[1:0] != 2'b00)
                  || (|i_paddr[ADDR_WIDTH-1:IDX_W+2])
                  || (i_pwrite && (i_paddr[IDX_W+1:2] == '0));

   assign ready = (state_q == ST_ACCESS) && (cnt_q == CNT_W'(WAIT_STATES));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      write_d = write_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      wr_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (setup) begin
               state_d = ST_ACCESS;
               cnt_d   = '0;
               idx_d   = i_paddr[IDX_W+1:2];
               write_d = i_pwrite;
               wdata_d = i_pwdata;
               err_d   = addr_err;
            end
         end
         ST_ACCESS: begin
            if (!i_psel) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (i_penable) begin
               if (ready) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  wr_en   = write_q && !err_q;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk_apb) begin
      if (i_rst_apb) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end

   apb_slave_regbank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_W      (IDX_W)
   ) u_regbank (
      .i_clk_apb (i_clk_apb),
      .i_rst_apb (i_rst_apb),
      .i_we      (wr_en),
      .i_waddr   (idx_q),
      .i_wdata   (wdata_q),
      .i_raddr   (idx_q),
      .o_rdata   (bank_rdata)
   );

   assign rd_word   = (idx_q == '0) ? DATA_WIDTH'(ID_VALUE) : bank_rdata;

   // All three outputs are decoded from registered state only.
   assign o_pready  = ready;
   assign o_pslverr = ready && err_q;
   assign o_prdata  = (ready && !write_q && !err_q) ? rd_word : '0;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: one instance with 2 wait states, one with none,
// driven over a shared bus and checked through a scoreboard queue.
module tb_apb_slave_mem;

   localparam logic [31:0] ID_WORD = 32'hA9B0_0001;

   logic        clk = 1'b0;
   logic        rst;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic        sel;

   logic [31:0] prdata0, prdata1;
   logic        pready0, pready1, pslverr0, pslverr1;
   logic        psel0, psel1;
   logic [31:0] prdata;
   logic        pready, pslverr;

   always #5 clk = ~clk;

   assign psel0   = psel & ~sel;
   assign psel1   = psel & sel;
   assign prdata  = sel ? prdata1  : prdata0;
   assign pready  = sel ? pready1  : pready0;
   assign pslverr = sel ? pslverr1 : pslverr0;

   apb_slave_mem #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16), .WAIT_STATES(2)
   ) dut_ws2 (
      .i_clk_apb(clk), .i_rst_apb(rst), .i_psel(psel0), .i_penable(penable),
      .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata),
      .o_prdata(prdata0), .o_pready(pready0), .o_pslverr(pslverr0)
   );

   apb_slave_mem #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16), .WAIT_STATES(0)
   ) dut_ws0 (
      .i_clk_apb(clk), .i_rst_apb(rst), .i_psel(psel1), .i_penable(penable),
      .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata),
      .o_prdata(prdata1), .o_pready(pready1), .o_pslverr(pslverr1)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      string       tag;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] model_mem [2][16];
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++)
         for (int r = 0; r < 16; r++)
            model_mem[d][r] = 32'h0;
   endtask

   // Entered and left #1 after a rising edge; leaves the bus idle.
   task automatic apb_xfer(input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, input string tag);
      exp_t e;
      bit   err;
      int   cyc;
      err   = (addr[1:0] != 2'b00) || (addr >= 32'd64) || (wr && addr == 32'd0);
      e.err = err;
      e.lat = (sel ? 0 : 2) + 1;
      e.tag = tag;
      if (wr || err)           e.rdata = 32'h0;
      else if (addr == 32'd0)  e.rdata = ID_WORD;
      else                     e.rdata = model_mem[sel][addr[5:2]];
      if (wr && !err) model_mem[sel][addr[5:2]] = data;
      sb_q.push_back(e);

      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
      @(posedge clk); #1;
      penable = 1'b1;
      cyc = 1;
      while (pready !== 1'b1 && cyc < 40) begin
         chk({tag, "_wait_prdata"}, prdata, 32'h0);
         @(posedge clk); #1;
         cyc++;
      end
      if (pready !== 1'b1) chk({tag, "_timeout"}, {31'h0, pready}, 32'h1);

      e = sb_q.pop_front();
      chk({e.tag, "_latency"}, cyc, e.lat);
      chk({e.tag, "_prdata"}, prdata, e.rdata);
      chk({e.tag, "_pslverr"}, {31'h0, pslverr}, {31'h0, e.err});
      $display("xfer %-12s dut=%0d %s addr=%h wdata=%h prdata=%h pslverr=%0b cycles=%0d",
               e.tag, sel, wr ? "WR" : "RD", addr, data, prdata, pslverr, cyc);

      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      chk({e.tag, "_idle_pready"}, {31'h0, pready}, 32'h0);
   endtask

   initial begin
      rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = 32'h0; pwdata = 32'h0; sel = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pready0",  {31'h0, pready0},  32'h0);
      chk("rst_pslverr0", {31'h0, pslverr0}, 32'h0);
      chk("rst_prdata0",  prdata0,           32'h0);
      chk("rst_pready1",  {31'h0, pready1},  32'h0);
      chk("rst_prdata1",  prdata1,           32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Two wait states: basic write/read, ID register, address errors.
      sel = 1'b0;
      apb_xfer(1'b1, 32'h04, 32'hDEADBEEF, "wr_04");
      apb_xfer(1'b0, 32'h04, 32'h0,        "rd_04");
      apb_xfer(1'b0, 32'h00, 32'h0,        "rd_id");
      apb_xfer(1'b1, 32'h00, 32'h1234,     "wr_id");
      apb_xfer(1'b0, 32'h00, 32'h0,        "rd_id2");
      apb_xfer(1'b0, 32'h40, 32'h0,        "rd_oob");
      apb_xfer(1'b1, 32'h06, 32'hFFFFFFFF, "wr_misal");
      apb_xfer(1'b1, 32'h3C, 32'h0BADF00D, "wr_last");
      apb_xfer(1'b0, 32'h3C, 32'h0,        "rd_last");
      apb_xfer(1'b0, 32'h04, 32'h0,        "rd_04_again");

      // Abort: psel drops during a wait state.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h55;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      chk("abort_wait_pready", {31'h0, pready}, 32'h0);
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      chk("abort_idle_pready", {31'h0, pready}, 32'h0);
      $display("xfer %-12s dut=%0d WR addr=%h aborted", "abort_10", sel, 32'h10);
      apb_xfer(1'b0, 32'h10, 32'h0, "rd_10_abrt");

      // Reset asserted during a write access.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'hCAFE0000;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_pready",  {31'h0, pready},  32'h0);
      chk("midrst_pslverr", {31'h0, pslverr}, 32'h0);
      chk("midrst_prdata",  prdata,           32'h0);
      rst = 1'b0; psel = 1'b0; penable = 1'b0;
      model_reset();
      $display("xfer %-12s dut=%0d WR addr=%h reset mid-access", "rst_14", sel, 32'h14);
      @(posedge clk); #1;
      apb_xfer(1'b0, 32'h14, 32'h0, "rd_14_rst");
      apb_xfer(1'b0, 32'h04, 32'h0, "rd_04_rst");

      // Zero wait states, back-to-back transfers.
      sel = 1'b1;
      apb_xfer(1'b1, 32'h08, 32'h13579BDF, "z_wr_08");
      apb_xfer(1'b1, 32'h0C, 32'h2468ACE0, "z_wr_0c");
      apb_xfer(1'b0, 32'h08, 32'h0,        "z_rd_08");
      apb_xfer(1'b0, 32'h0C, 32'h0,        "z_rd_0c");
      for (int i = 1; i < 6; i++) begin
         logic [31:0] a;
         a = 32'(i * 8);
         apb_xfer(1'b1, a, $urandom, $sformatf("z_wr_r%0d", i));
         apb_xfer(1'b0, a, 32'h0,    $sformatf("z_rd_r%0d", i));
      end
      apb_xfer(1'b0, 32'h00, 32'h0, "z_rd_id");
      apb_xfer(1'b1, 32'h41, 32'h1, "z_wr_bad");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 Parameter DATA_WIDTH, 32, APB data width.
REQ-002 Parameter ADDR_WIDTH, 32, APB address width.
REQ-003 Parameter DEPTH, 16, number of 32-bit registers; must be a power of two.
REQ-004 Parameter WAIT_STATES, 2, wait cycles inserted per transfer (0..15).
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 i_clk_apb  input  1  APB clock; all state updates on its rising edge.
REQ-007 i_rst_apb  input  1  synchronous active-high reset.
REQ-008 i_psel  input  1  slave select from the APB master bridge.
REQ-009 i_penable  input  1  access phase indicator.
REQ-010 i_pwrite  input  1  1 = write, 0 = read.
REQ-011 i_paddr  input  ADDR_WIDTH  byte address.
REQ-012 i_pwdata  input  DATA_WIDTH  write data.
REQ-013 o_prdata  output  DATA_WIDTH  read data, valid only while o_pready=1 on a read.
REQ-014 o_pready  output  1  transfer-complete indication.
REQ-015 o_pslverr  output  1  error response, valid only while o_pready=1.

Function
REQ-016 The FSM SHALL have two states: IDLE and ACCESS.
REQ-017 IDLE -> ACCESS on the edge where i_psel=1 and i_penable=0 (setup phase).
- That edge latches i_paddr, i_pwrite and i_pwdata.
- The same edge clears the wait counter to 0.
REQ-018 In ACCESS, o_pready SHALL be 1 exactly when the wait counter equals WAIT_STATES.
- o_pready is decoded from registered state only; it has no combinational path from inputs.
REQ-019 In ACCESS with i_psel=1, i_penable=1 and counter < WAIT_STATES, the counter SHALL increment by 1 per cycle.
REQ-020 The transfer completes on the edge with i_psel=1, i_penable=1 and o_pready=1.
- The FSM returns to IDLE and the counter clears.
- Access-phase latency is WAIT_STATES+1 cycles.
REQ-021 Write completion without error SHALL update the addressed register on the completion edge.
REQ-022 A read SHALL drive o_prdata from the latched-address register while o_pready=1.
- o_prdata SHALL be 0 at all other times and on errored reads.
REQ-023 Register index SHALL be latched paddr[log2(DEPTH)+1:2].
REQ-024 The address is decoded as an error when paddr[1:0]!=0 or paddr >= DEPTH*4.
REQ-025 Register 0 SHALL be read-only and return constant ID_VALUE; a write to it is an error.
REQ-026 o_pslverr SHALL equal the latched error decode while o_pready=1, else 0.
- An errored write leaves all registers unchanged.
REQ-027 If i_psel drops to 0 while in ACCESS before completion, the FSM SHALL abort to IDLE with no register update.
REQ-028 Back-to-back transfers: a setup phase in the cycle after completion SHALL be accepted with no idle cycle required.
REQ-029 In IDLE, o_pready and o_pslverr SHALL be 0.

Reset
REQ-030 While i_rst_apb=1 on a clock edge: state=IDLE, counter=0, registers 1..DEPTH-1 = 0, o_pready=0, o_pslverr=0, o_prdata=0.
REQ-031 Reset asserted mid-transfer SHALL abort it with no register update; the master sees no completion.

Structure
REQ-032 Package apb_slave_pkg SHALL hold the state enum, ID_VALUE (32'hA9B0_0001) and default parameter constants.
REQ-033 Storage SHALL be a sub-module apb_slave_regbank with one write port and one asynchronous read port.
- Target size: 120-400 lines of RTL total.

Verification
REQ-034 Write 0xDEADBEEF to 0x04, then read 0x04, WAIT_STATES=2 -> o_pready high on the 3rd access cycle of each transfer; read returns 0xDEADBEEF with o_pslverr=0.
REQ-035 Read 0x00 -> 0xA9B0_0001; write 0x1234 to 0x00 -> o_pslverr=1; re-read still returns 0xA9B0_0001.
REQ-036 Read 0x40 (DEPTH=16) and write to 0x06 -> both complete with o_pslverr=1 and o_prdata=0; no register changes.
REQ-037 WAIT_STATES=0: back-to-back writes to 0x08 and 0x0C, then reads -> each transfer completes in 2 cycles; values are read back exactly.
REQ-038 Write 0x55 to 0x10; drop i_psel during a wait state; then read 0x10 -> returns 0 (write aborted).
REQ-039 Assert i_rst_apb during a write access -> next cycle shows o_pready=0 and state IDLE; a read of the target register returns 0.
